// File: rtl/updown_bounded_counter_pkg.sv
// Shared definitions for the bounded up/down counter: mode encoding and operation select.
package counter_pkg;

    localparam logic MODE_WRAP     = 1'b0;
    localparam logic MODE_SATURATE = 1'b1;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_UP   = 2'd1,
        OP_DOWN = 2'd2
    } op_t;

endpackage

// File: rtl/updown_bounded_counter_step_calc.sv
// Combinational next-count calculation for one bounded up/down step.
// Assumes count <= max_value and s <= max_value; the top guarantees both.
module bounded_step_calc
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] max_value,
    input  logic             mode,
    input  op_t              op,
    output logic [WIDTH-1:0] next_count,
    output logic             ovf,
    output logic             unf
);

    localparam int W1 = WIDTH + 1;

    logic [W1-1:0]    sum;
    logic [W1-1:0]    limit;
    logic [WIDTH-1:0] down_plain;
    logic [WIDTH-1:0] up_wrap;
    logic [WIDTH-1:0] down_wrap;

    // One extra bit keeps count + s and count + max + 1 exact.
    assign sum        = {1'b0, count} + {1'b0, s};
    assign limit      = {1'b0, max_value};
    assign down_plain = count - s;
    assign up_wrap    = WIDTH'(sum - limit - W1'(1));
    assign down_wrap  = WIDTH'({1'b0, count} + limit + W1'(1) - {1'b0, s});

    always_comb begin
        next_count = count;
        ovf        = 1'b0;
        unf        = 1'b0;
        case (op)
            OP_UP: begin
                if (sum <= limit) begin
                    next_count = sum[WIDTH-1:0];
                end else begin
                    ovf        = 1'b1;
                    next_count = (mode == MODE_SATURATE) ? max_value : up_wrap;
                end
            end
            OP_DOWN: begin
                if (s <= count) begin
                    next_count = down_plain;
                end else begin
                    unf        = 1'b1;
                    next_count = (mode == MODE_SATURATE) ? '0 : down_wrap;
                end
            end
            default: begin
                next_count = count;
            end
        endcase
    end

endmodule

// File: rtl/updown_bounded_counter.sv
// Parametrised up/down counter with runtime upper bound, wrap/saturate mode,
// synchronous clear/load and registered overflow/underflow pulses.
module updown_bounded_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH       = 8,
    parameter int              STEP_W      = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic              increment,
    input  logic              decrement,
    input  logic [STEP_W-1:0] step,
    input  logic              mode,
    input  logic [WIDTH-1:0]  max_value,
    output logic [WIDTH-1:0]  count,
    output logic              at_max,
    output logic              at_min,
    output logic              overflow,
    output logic              underflow
);

    localparam int CW = (STEP_W > WIDTH) ? STEP_W : WIDTH;

    logic [CW-1:0]    step_x;
    logic [CW-1:0]    max_x;
    logic [WIDTH-1:0] s_eff;
    op_t              op;
    logic [WIDTH-1:0] calc_count;
    logic             calc_ovf;
    logic             calc_unf;

    // Compare at the wider of the two widths so a large step is never truncated.
    assign step_x = CW'(step);
    assign max_x  = CW'(max_value);
    assign s_eff  = (step_x <= max_x) ? step_x[WIDTH-1:0] : max_value;

    always_comb begin
        op = OP_HOLD;
        if (s_eff != '0) begin
            if (increment && !decrement) begin
                op = OP_UP;
            end else if (decrement && !increment) begin
                op = OP_DOWN;
            end
        end
    end

    bounded_step_calc #(
        .WIDTH(WIDTH)
    ) u_step_calc (
        .count      (count),
        .s          (s_eff),
        .max_value  (max_value),
        .mode       (mode),
        .op         (op),
        .next_count (calc_count),
        .ovf        (calc_ovf),
        .unf        (calc_unf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= RESET_VALUE;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            count     <= RESET_VALUE;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (load) begin
            count     <= (load_value <= max_value) ? load_value : max_value;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (count > max_value) begin
            count     <= max_value;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= calc_count;
            overflow  <= calc_ovf;
            underflow <= calc_unf;
        end
    end

    assign at_max = (count == max_value);
    assign at_min = (count == '0);

endmodule
